current_pi_ctrl: RTL and testbench
==================================

Name: current_pi_ctrl

Overview:
- Closed-loop current controller and consumer of the assist block's target_curr.
- Compares target_curr with the measured, averaged motor current and runs a decimated PI loop.
- Produces a saturated 12-bit drive_duty command for the PWM / commutation stage.
- Two-stage pipeline; one update per measurement strobe.

Parameters:
INT_DEC_W, 2, width of integrator decimation counter; integrator updates once every 2^INT_DEC_W accepted samples
INT_SHIFT, 5, right-shift applied to integrator when forming I term (I term = integ[16+0:INT_SHIFT] truncated to 12 bits)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  loop enable; low = motor off, loop held cleared
target_curr  input  12  unsigned commanded current from the assist block
avg_curr  input  12  unsigned measured averaged motor current
avg_curr_vld  input  1  one-cycle strobe, avg_curr valid; target_curr sampled same cycle
drive_duty  output  12  unsigned duty command, held between updates
duty_vld  output  1  one-cycle pulse when drive_duty updated

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset: drive_duty=0, duty_vld=0, integ=0, dec_cnt=0, stage-1 valid=0.
- Accept: sample accepted on a cycle where avg_curr_vld=1 and en=1; ignored otherwise.
- Stage 1, accept cycle:
  - err = {1'b0,target_curr} - {1'b0,avg_curr}, 13-bit signed.
  - err_sat = err saturated to 12-bit signed [-2048, 2047]; registered.
  - dec_cnt increments and wraps at 2^INT_DEC_W.
- Integrator:
  - Updates only on an accepted sample where dec_cnt == 2^INT_DEC_W-1 before increment, i.e. the 4th, 8th, ... sample.
  - integ_nxt = integ + sext(err_sat), computed 19-bit signed.
  - Negative result clips to 0; result > 18'h1FFFF clips to 18'h1FFFF.
  - integ is 18-bit and always >= 0.
- Stage 2, cycle after accept:
  - P = sext14(err_sat).
  - I = {2'b00, integ[16:INT_SHIFT] truncated to 12 bits}, using the already-updated integ.
  - sum = P + I, 14-bit signed; cannot overflow.
  - drive_duty = 0 if sum<0, 12'hFFF if sum>12'hFFF, else sum[11:0].
  - duty_vld pulses 1 cycle.
- Latency: avg_curr_vld at cycle N -> drive_duty/duty_vld at N+2; one sample per cycle is sustained.
- Back-to-back strobes: each produces its own result; integrator sees samples in order.
- en low on any cycle, taking priority over a coincident strobe:
  - integ<=0, dec_cnt<=0, stage-1 valid<=0, drive_duty<=0 next cycle.
  - No duty_vld for the in-flight sample.
- en rising: loop restarts from a cleared state; first output is pure P term.
- rst mid-operation: same as the reset state next cycle, overrides en and strobes.
- drive_duty holds its value when no strobe arrives; no timeout.

Test Plan:
1. rst=1 for 2 cycles with strobes active -> drive_duty=0, duty_vld=0, integ=0 throughout.
2. en=1, target=0x400, avg=0x200, single strobe at N -> duty_vld at N+2, drive_duty=0x200, integ still 0.
3. Same inputs, 4 consecutive strobes -> outputs 0x200, 0x200, 0x200, then 0x210 (integ=0x200, I=0x10).
4. target=0xFFF, avg=0x000, continuous strobes -> err_sat=0x7FF, integ saturates at 0x1FFFF and never wraps, drive_duty=0xFFF.
5. target=0x000, avg=0xFFF, strobes from reset -> err_sat=-2048, integ stays 0, drive_duty=0.
6. Build integ>0 per scenario 4, then drop en the cycle after a strobe -> that strobe gives no duty_vld, drive_duty=0, integ=0. Re-enable with target=0x100, avg=0 -> drive_duty=0x100.

Source files
------------

// File: rtl/current_pi_ctrl.sv
// Decimated PI current loop: compares commanded and measured motor current and
// produces a saturated 12-bit duty command two cycles after each accepted sample.
module current_pi_ctrl #(
  parameter int INT_DEC_W = 2,
  parameter int INT_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] target_curr,
  input  logic [11:0] avg_curr,
  input  logic        avg_curr_vld,
  output logic [11:0] drive_duty,
  output logic        duty_vld
);

  localparam int DATA_W  = 12;
  localparam int INTEG_W = 18;
  localparam int SUM_W   = 14;
  localparam logic [INTEG_W-1:0] INTEG_MAX = 18'h1FFFF;

  function automatic logic signed [DATA_W-1:0] sat_err(input logic signed [DATA_W:0] e);
    if (e > 13'sd2047)
      return 12'sd2047;
    else if (e < -13'sd2048)
      return -12'sd2048;
    else
      return $signed(e[DATA_W-1:0]);
  endfunction

  function automatic logic [INTEG_W-1:0] sat_integ(input logic signed [INTEG_W:0] v);
    if (v < 19'sd0)
      return '0;
    else if (v > 19'sd131071)
      return INTEG_MAX;
    else
      return v[INTEG_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_duty(input logic signed [SUM_W-1:0] s);
    if (s < 14'sd0)
      return 12'h000;
    else if (s > 14'sd4095)
      return 12'hFFF;
    else
      return s[DATA_W-1:0];
  endfunction

  logic                        accept;
  logic signed [DATA_W:0]      err_p0;
  logic signed [DATA_W-1:0]    err_sat_p0;
  logic                        integ_upd;
  logic signed [INTEG_W:0]     integ_sum;
  logic [INTEG_W-1:0]          integ;
  logic [INT_DEC_W-1:0]        dec_cnt;

  logic signed [DATA_W-1:0]    err_p1;
  logic                        vld_p1;
  logic [DATA_W-1:0]           i_raw_p1;
  logic signed [SUM_W-1:0]     p_term_p1;
  logic signed [SUM_W-1:0]     i_term_p1;
  logic signed [SUM_W-1:0]     sum_p1;

  // Stage 0: error formation and integrator candidate
  assign accept     = avg_curr_vld & en;
  assign err_p0     = $signed({1'b0, target_curr}) - $signed({1'b0, avg_curr});
  assign err_sat_p0 = sat_err(err_p0);
  assign integ_upd  = accept && (dec_cnt == '1);
  assign integ_sum  = $signed({1'b0, integ}) +
                      $signed({{(INTEG_W-DATA_W+1){err_sat_p0[DATA_W-1]}}, err_sat_p0});

  always_ff @(posedge clk) begin
    if (accept)
      err_p1 <= err_sat_p0;
  end

  // Stage 1: P + I using the integrator value written on the accept edge
  assign i_raw_p1  = DATA_W'(integ >> INT_SHIFT);
  assign p_term_p1 = $signed({{(SUM_W-DATA_W){err_p1[DATA_W-1]}}, err_p1});
  assign i_term_p1 = $signed({2'b00, i_raw_p1});
  assign sum_p1    = p_term_p1 + i_term_p1;

  // Disabling the loop clears everything, including an in-flight sample
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      vld_p1     <= 1'b0;
      dec_cnt    <= '0;
      integ      <= '0;
      drive_duty <= '0;
      duty_vld   <= 1'b0;
    end else begin
      vld_p1   <= accept;
      duty_vld <= vld_p1;
      if (accept)
        dec_cnt <= dec_cnt + INT_DEC_W'(1);
      if (integ_upd)
        integ <= sat_integ(integ_sum);
      if (vld_p1)
        drive_duty <= sat_duty(sum_p1);
    end
  end

endmodule

// File: tb/tb_current_pi_ctrl.sv
// Self-checking bench for current_pi_ctrl: directed scenarios plus randomized
// traffic against a sample-level behavioural model of the PI loop.
module tb_current_pi_ctrl;

  localparam int DEC_N = 4;
  localparam int SHIFT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] target_curr = '0;
  logic [11:0] avg_curr = '0;
  logic        avg_curr_vld = 1'b0;
  logic [11:0] drive_duty;
  logic        duty_vld;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: integrator, sample count, one result waiting to appear
  int m_integ = 0;
  int m_cnt = 0;
  bit m_pend = 0;
  int m_pend_val = 0;
  int m_duty = 0;
  bit m_dvld = 0;

  current_pi_ctrl #(.INT_DEC_W(2), .INT_SHIFT(5)) dut (
    .clk(clk), .rst(rst), .en(en), .target_curr(target_curr),
    .avg_curr(avg_curr), .avg_curr_vld(avg_curr_vld),
    .drive_duty(drive_duty), .duty_vld(duty_vld)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic tick(input bit r, input bit e, input int t, input int a, input bit v);
    int err;
    rst = r; en = e; avg_curr_vld = v;
    target_curr = t[11:0]; avg_curr = a[11:0];
    @(posedge clk);
    if (r || !e) begin
      m_integ = 0; m_cnt = 0; m_pend = 0; m_duty = 0; m_dvld = 0;
    end else begin
      m_dvld = m_pend;
      if (m_pend) m_duty = m_pend_val;
      m_pend = v;
      if (v) begin
        err = clampi(t - a, -2048, 2047);
        if (m_cnt == DEC_N - 1) m_integ = clampi(m_integ + err, 0, 131071);
        m_cnt = (m_cnt + 1) % DEC_N;
        m_pend_val = clampi(err + ((m_integ >> SHIFT) & 4095), 0, 4095);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 'h400, 'h200, 1);
      n_cmp++;
      if (drive_duty !== 12'h000 || duty_vld !== 1'b0 || dut.integ !== 18'h0) begin
        n_bad++;
        $display("FAIL reset: duty=%h vld=%b integ=%h, required 000/0/00000",
                 drive_duty, duty_vld, dut.integ);
      end
    end
  endtask

  task automatic test_single();
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 'h400, 'h200, 1);
    n_cmp++;
    if (duty_vld !== 1'b0) begin
      n_bad++; $display("FAIL single_early: vld=%b, required 0", duty_vld);
    end
    tick(0, 1, 'h400, 'h200, 0);
    n_cmp++;
    if (duty_vld !== 1'b1 || drive_duty !== 12'h200 || dut.integ !== 18'h0) begin
      n_bad++;
      $display("FAIL single: vld=%b duty=%h integ=%h, required 1/200/00000",
               duty_vld, drive_duty, dut.integ);
    end
    tick(0, 1, 'h400, 'h200, 0);
    n_cmp++;
    if (duty_vld !== 1'b0 || drive_duty !== 12'h200) begin
      n_bad++; $display("FAIL single_hold: vld=%b duty=%h, required 0/200", duty_vld, drive_duty);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_v [4];
    exp_v[0] = 12'h200; exp_v[1] = 12'h200; exp_v[2] = 12'h200; exp_v[3] = 12'h210;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 'h400, 'h200, i < 4);
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (duty_vld !== 1'b1 || drive_duty !== exp_v[i-1]) begin
          n_bad++;
          $display("FAIL back_to_back[%0d]: vld=%b duty=%h, required 1/%h",
                   i - 1, duty_vld, drive_duty, exp_v[i-1]);
        end
      end
    end
    n_cmp++;
    if (dut.integ !== 18'h200) begin
      n_bad++; $display("FAIL b2b_integ: integ=%h, required 00200", dut.integ);
    end
  endtask

  task automatic test_sat_high(input bit do_reset);
    if (do_reset) tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      tick(0, 1, 'hFFF, 'h000, 1);
      n_cmp++;
      if (dut.integ > 18'h1FFFF || dut.integ !== 18'(m_integ) ||
          duty_vld !== m_dvld || drive_duty !== 12'(m_duty)) begin
        n_bad++;
        $display("FAIL sat_high[%0d]: integ=%h duty=%h vld=%b, required %h/%h/%b",
                 i, dut.integ, drive_duty, duty_vld, m_integ, m_duty, m_dvld);
      end
    end
    n_cmp++;
    if (dut.integ !== 18'h1FFFF || drive_duty !== 12'hFFF) begin
      n_bad++;
      $display("FAIL sat_high_end: integ=%h duty=%h, required 1FFFF/FFF", dut.integ, drive_duty);
    end
  endtask

  task automatic test_sat_low();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick(0, 1, 'h000, 'hFFF, 1);
      n_cmp++;
      if (dut.integ !== 18'h0 || drive_duty !== 12'h000 || duty_vld !== (i > 0)) begin
        n_bad++;
        $display("FAIL sat_low[%0d]: integ=%h duty=%h vld=%b, required 00000/000/%b",
                 i, dut.integ, drive_duty, duty_vld, i > 0);
      end
    end
  endtask

  task automatic test_en_drop();
    test_sat_high(1);
    tick(0, 0, 'hFFF, 'h000, 1);
    n_cmp++;
    if (duty_vld !== 1'b0 || drive_duty !== 12'h000 || dut.integ !== 18'h0) begin
      n_bad++;
      $display("FAIL en_drop: vld=%b duty=%h integ=%h, required 0/000/00000",
               duty_vld, drive_duty, dut.integ);
    end
    tick(0, 0, 'h100, 'h000, 0);
    n_cmp++;
    if (duty_vld !== 1'b0) begin
      n_bad++; $display("FAIL en_drop_idle: vld=%b, required 0", duty_vld);
    end
    tick(0, 1, 'h100, 'h000, 1);
    tick(0, 1, 'h100, 'h000, 0);
    n_cmp++;
    if (duty_vld !== 1'b1 || drive_duty !== 12'h100) begin
      n_bad++;
      $display("FAIL en_restart: vld=%b duty=%h, required 1/100", duty_vld, drive_duty);
    end
  endtask

  task automatic test_random();
    int t, a;
    bit r, e, v;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 15) != 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: begin t = 'hFFF; a = $urandom_range(0, 255); end
        1: begin t = $urandom_range(0, 255); a = 'hFFF; end
        default: begin t = $urandom_range(0, 4095); a = $urandom_range(0, 4095); end
      endcase
      tick(r, e, t, a, v);
      n_cmp++;
      if (duty_vld !== m_dvld || drive_duty !== 12'(m_duty) || dut.integ !== 18'(m_integ)) begin
        n_bad++;
        $display("FAIL random[%0d]: vld=%b duty=%h integ=%h, required %b/%h/%h",
                 i, duty_vld, drive_duty, dut.integ, m_dvld, m_duty, m_integ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sat_high(1);
    test_sat_low();
    test_en_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
